// File: rtl/serial_add.sv
// serial_add: multi-cycle unsigned adder, DIGIT bits per clock, LSB first.
//
// Operands are captured on an accepted Start edge and shifted right through
// the digit adder. Each sum digit enters the top of a result shift register.
// After N = WIDTH/DIGIT digits, the completed word is copied to Sum/Cout and
// Done pulses for one cycle.
//
// Optional feature, macro SERIAL_ADD_SUB_EN: adds a Sub input (A - B, done as
// A + ~B + 1) and an Ovf output (two's-complement signed overflow).
//
// Parameter constraints: WIDTH >= 2, and DIGIT must divide WIDTH exactly.
module serial_add #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub,
  output logic             Ovf,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  // Number of digit steps per operation, and a counter wide enough for N-1.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Operand and carry values as they are latched on an accepted Start.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Digit adder outputs.
  logic [DIGIT-1:0] digit_sum;
  logic             digit_cout;
  logic             chain_c;

`ifdef SERIAL_ADD_SUB_EN
  logic ovf_q, ovf_d;
  logic msb_cin;

  // Subtraction is A + ~B + 1. The forced carry replaces Cin.
  assign b_eff   = Sub ? ~B : B;
  assign cin_eff = Sub ? 1'b1 : Cin;
`else
  assign b_eff   = B;
  assign cin_eff = Cin;
`endif

  // Ripple the registered carry through the low DIGIT bits of the operands.
  always_comb begin
    // NOTE: blocking assignments here model the ripple chain bit by bit within
    // one evaluation. Every variable gets a default first, so no latch is inferred.
    digit_sum = '0;
    chain_c   = carry_q;
`ifdef SERIAL_ADD_SUB_EN
    msb_cin   = 1'b0;
`endif
    for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      // The carry into the top bit of the last digit is the carry into the word MSB.
      msb_cin = chain_c;
`endif
      digit_sum[i] = a_q[i] ^ b_q[i] ^ chain_c;
      chain_c      = (a_q[i] & b_q[i]) | (chain_c & (a_q[i] ^ b_q[i]));
    end
    digit_cout = chain_c;
  end

  // Next-state logic: capture on Start, step one digit per RUN cycle, publish on exit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts Start, so back-to-back operations have no idle bubble.
        if (Start) begin
          state_d = S_RUN;
          a_d     = A;
          b_d     = b_eff;
          carry_d = cin_eff;
          cnt_d   = CW'(N - 1);
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // The new digit enters the top of the result. After N steps, the first
        // digit has reached bit 0.
        res_d   = WIDTH'({digit_sum, res_q} >> DIGIT);
        carry_d = digit_cout;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          sum_d   = res_d;
          cout_d  = digit_cout;
`ifdef SERIAL_ADD_SUB_EN
          ovf_d   = msb_cin ^ digit_cout;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: every register is cleared by reset, including the shift registers.
    // An abandoned operation must leave no visible residue.
    if (!Reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy = (state_q == S_RUN);
  assign Done = (state_q == S_DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
`ifdef SERIAL_ADD_SUB_EN
  assign Ovf  = ovf_q;
`endif

endmodule
